lsu_mem_sequencer: RTL and testbench
====================================

Name: lsu_mem_sequencer

Overview:
Multi-cycle controller that sequences the load-word / store-word datapath against a variable-latency data memory. It decodes the accepted instruction and drives ImmSrc (I vs S immediate select for the sign-extend unit) and ALUSrc. It latches the effective address from the ALU, runs a req/ready handshake with data memory, and asserts RegWrite/ResultSrc for the write-back. It sits between the fetch/PC logic (via stall/done) and the register file, ALU and data memory.

Parameters:
TIMEOUT, 16, max MEM-state cycles waiting for mem_ready before aborting (>=2)
CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  Instr valid this cycle; sampled only in IDLE
Instr  input  32  instruction word
alu_result  input  32  effective address from ALU (rs1 + ImmExt)
mem_ready  input  1  data memory completes access this cycle
ImmSrc  output  1  1 = S-type immediate, 0 = I-type immediate
ALUSrc  output  1  1 = ALU operand B from ImmExt
mem_req  output  1  memory access request
mem_we  output  1  1 = store, valid with mem_req
mem_addr  output  32  registered effective address
RegWrite  output  1  register file write enable
ResultSrc  output  1  1 = write-back data from memory
stall  output  1  hold PC/fetch
done  output  1  one-cycle completion pulse
illegal  output  1  with done: instruction not lw/sw
timeout  output  1  with done: memory did not respond
misalign  output  1  with done: address[1:0] != 0 (see Optional Feature)

Behaviour:
- Decode: lw = opcode 0000011 & funct3 010; sw = opcode 0100011 & funct3 010; anything else is illegal.
- In IDLE with instr_valid=1: latch Instr, is_store and is_load.
- States: IDLE, EXEC, MEM, WB, DONE.
- IDLE -> EXEC if instr_valid and decoded lw/sw; IDLE -> DONE (illegal=1) if instr_valid and illegal; otherwise stay in IDLE.
- EXEC (1 cycle):
  - ImmSrc = is_store, ALUSrc = 1.
  - Register mem_addr <= alu_result.
  - Clear wait counter; go to MEM.
- MEM:
  - mem_req = 1, mem_we = is_store, mem_addr stable.
  - ImmSrc and ALUSrc hold their EXEC values.
  - mem_ready=1: load -> WB, store -> DONE.
  - Otherwise the counter increments; when it reaches TIMEOUT-1 without ready, go to DONE with timeout=1 and deassert mem_req next cycle.
  - mem_ready in the same cycle as the timeout limit counts as success (ready wins).
- WB (1 cycle): RegWrite = 1, ResultSrc = 1 -> DONE.
- DONE (1 cycle): done = 1; illegal/timeout/misalign valid only while done = 1 -> IDLE.
- stall = 1 in EXEC, MEM and WB. stall = 0 in IDLE and DONE.
- instr_valid is ignored outside IDLE. A new instruction is accepted in the cycle after done.
- mem_ready outside MEM is ignored.
- Latency, ready on first MEM cycle:
  - lw: accept at cycle 0, done at cycle 4.
  - sw: done at cycle 3.
  - Each cycle mem_ready is delayed adds one cycle.
- Reset (any state, including mid-MEM): state = IDLE, counter = 0, mem_addr = 0, latched instr = 0. All outputs 0: mem_req is dropped and no RegWrite or done is issued for the aborted access.
- Outputs are decoded from registered state only; no combinational path from instr_valid to any output.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: in EXEC, if alu_result[1:0] != 2'b00, skip MEM and WB and go to DONE with misalign=1. mem_req and RegWrite are never asserted for that instruction.
- Undefined: no alignment check; misalign is tied to 0; mem_addr is passed through unmodified.

Test Plan:
- lw x5,8(x2): Instr=0x00812283, alu_result=0x00000108, ready on first MEM cycle -> ImmSrc=0, mem_req=1, mem_we=0, mem_addr=0x108; RegWrite=1 at cycle 3; done at cycle 4; stall high for cycles 1-3.
- sw x5,12(x2): Instr=0x00512623, alu_result=0x0000010C, ready after 3 wait cycles -> ImmSrc=1, mem_we=1 for 4 MEM cycles; RegWrite never 1; done at cycle 6.
- Timeout: lw with mem_ready=0 and TIMEOUT=16 -> 16 MEM cycles, then done=1, timeout=1, RegWrite never asserted; mem_ready=1 on the 16th cycle -> normal completion instead.
- Illegal: Instr=0x00000033 (add) -> done=1, illegal=1 one cycle after accept; mem_req never asserted.
- Reset mid-MEM: assert rst for 1 cycle during MEM of sw -> next cycle all outputs 0, state IDLE; a following lw completes normally.
- With MISALIGN_TRAP_EN: lw with alu_result=0x00000102 -> done at cycle 2 with misalign=1 and no mem_req. Without the macro: same stimulus -> mem_addr=0x102 and misalign=0.

Source files
------------

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer
//   Multi-cycle controller for lw/sw against a variable-latency data memory.
//   It decodes the accepted instruction, selects the I/S immediate and the
//   ALU immediate operand, and registers the effective address. It then runs
//   a req/ready handshake with bounded wait and drives register write-back.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   instr_valid/Instr : instruction offer, sampled only while idle
//   alu_result        : effective address (rs1 + ImmExt), taken in EXEC
//   mem_ready         : memory completes the access this cycle (MEM only)
//   ImmSrc, ALUSrc    : sign-extend select (1 = S-type), ALU B = ImmExt
//   mem_req/mem_we    : memory request, store qualifier
//   mem_addr          : registered effective address
//   RegWrite/ResultSrc: write-back enable, write-back from memory
//   stall             : hold PC/fetch while the access is in flight
//   done              : one-cycle completion pulse
//   illegal/timeout/misalign : status, valid only with done
//
// Build option
//   MISALIGN_TRAP_EN  : when defined, a non-word-aligned address skips the
//                       memory access and completes with misalign = 1.
module lsu_mem_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] Instr,
  input  logic [31:0] alu_result,
  input  logic        mem_ready,
  output logic        ImmSrc,
  output logic        ALUSrc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        RegWrite,
  output logic        ResultSrc,
  output logic        stall,
  output logic        done,
  output logic        illegal,
  output logic        timeout,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       instr_q,    instr_d;
  logic              is_store_q, is_store_d;
  logic              is_load_q,  is_load_d;
  logic              illegal_q,  illegal_d;
  logic              timeout_q,  timeout_d;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
`endif

  logic dec_load;
  logic dec_store;
  logic unused_instr;

  assign dec_load  = (Instr[6:0] == 7'b0000011) && (Instr[14:12] == 3'b010);
  assign dec_store = (Instr[6:0] == 7'b0100011) && (Instr[14:12] == 3'b010);

  // The latched instruction word is kept for visibility; control uses the
  // decoded flags captured alongside it.
  assign unused_instr = ^instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      is_store_q <= 1'b0;
      is_load_q  <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      is_store_q <= is_store_d;
      is_load_q  <= is_load_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    is_store_d = is_store_q;
    is_load_d  = is_load_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      S_IDLE: begin
        illegal_d = 1'b0;
        timeout_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        if (instr_valid) begin
          instr_d    = Instr;
          is_load_d  = dec_load;
          is_store_d = dec_store;
          if (dec_load || dec_store) begin
            state_d = S_EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_EXEC: begin
        mem_addr_d = alu_result;
        cnt_d      = '0;
        state_d    = S_MEM;
`ifdef MISALIGN_TRAP_EN
        if (alu_result[1:0] != 2'b00) begin
          misalign_d = 1'b1;
          state_d    = S_DONE;
        end
`endif
      end
      S_MEM: begin
        // Ready is checked before the limit so a response on the last
        // permitted cycle still completes normally.
        if (mem_ready) begin
          state_d = is_load_q ? S_WB : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ImmSrc    = 1'b0;
    ALUSrc    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;
    misalign  = 1'b0;
    case (state_q)
      S_EXEC: begin
        ImmSrc = is_store_q;
        ALUSrc = 1'b1;
        stall  = 1'b1;
      end
      S_MEM: begin
        ImmSrc  = is_store_q;
        ALUSrc  = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_store_q;
        stall   = 1'b1;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        stall     = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        timeout = timeout_q;
`ifdef MISALIGN_TRAP_EN
        misalign = misalign_q;
`endif
      end
      default: ;
    endcase
  end

  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
module tb_lsu_mem_sequencer;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] I_LW  = 32'h0081_2283;
  localparam logic [31:0] I_SW  = 32'h0051_2623;
  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_LB  = 32'h0001_0283;
  localparam logic [31:0] I_SH  = 32'h0051_1623;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] alu_result;
  logic        mem_ready;
  logic        ImmSrc, ALUSrc, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic        RegWrite, ResultSrc, stall, done, illegal, timeout, misalign;

  lsu_mem_sequencer #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .Instr(Instr),
    .alu_result(alu_result), .mem_ready(mem_ready), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .stall(stall), .done(done),
    .illegal(illegal), .timeout(timeout), .misalign(misalign)
  );

  typedef struct {
    int          done_cyc;
    int          n_req;
    int          n_stall;
    int          n_rw;
    bit          ill;
    bit          tmo;
    bit          mis;
    bit          we;
    bit          imm;
    bit          aborted;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] addr;
    int          wait_n;   // MEM cycles before ready; -1 = never
    bit          noise;    // toggle ignored inputs while busy
    int          lat;
    int          n_req;
    int          n_rw;
    bit          ill;
    bit          tmo;
    bit          mis;
    bit          we;
    bit          imm;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_at_pos = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rst_at_pos <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] addr,
                              input int wait_n, input bit noise, input int lat,
                              input int n_req, input int n_rw, input bit ill,
                              input bit tmo, input bit mis, input bit we, input bit imm);
    vec_t v;
    v.ins = ins; v.addr = addr; v.wait_n = wait_n; v.noise = noise; v.lat = lat;
    v.n_req = n_req; v.n_rw = n_rw; v.ill = ill; v.tmo = tmo; v.mis = mis;
    v.we = we; v.imm = imm;
    return v;
  endfunction

  // Monitor: per-cycle observation plus scoreboard pop on every done.
  int   m_req = 0, m_stall = 0, m_rw = 0, m_rw_cyc = -1;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_at_pos) begin
        chk("reset_outputs",
            32'({ImmSrc, ALUSrc, mem_req, mem_we, RegWrite, ResultSrc, stall,
                 done, illegal, timeout, misalign}), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        m_req = 0; m_stall = 0; m_rw = 0; m_rw_cyc = -1;
        if (q.size() > 0 && q[0].aborted) void'(q.pop_front());
      end else begin
        if (mem_req) begin
          m_req++;
          if (q.size() == 0) begin
            chk("req_without_expectation", 32'd1, 32'd0);
          end else begin
            chk("mem_we", 32'(mem_we), 32'(q[0].we));
            chk("imm_src", 32'(ImmSrc), 32'(q[0].imm));
            chk("alu_src", 32'(ALUSrc), 32'd1);
            chk("mem_addr", mem_addr, q[0].addr);
          end
        end
        if (stall) m_stall++;
        if (RegWrite) begin
          m_rw++;
          m_rw_cyc = cyc;
        end
        chk("result_src_eq_regwrite", 32'(ResultSrc), 32'(RegWrite));
        if (!done) begin
          chk("status_idle", 32'({illegal, timeout, misalign}), 32'd0);
        end else begin
          chk("stall_at_done", 32'(stall), 32'd0);
          if (q.size() == 0) begin
            chk("done_without_expectation", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_for_aborted", 32'(e.aborted), 32'd0);
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("timeout", 32'(timeout), 32'(e.tmo));
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("req_cycles", 32'(m_req), 32'(e.n_req));
            chk("stall_cycles", 32'(m_stall), 32'(e.n_stall));
            chk("regwrite_cycles", 32'(m_rw), 32'(e.n_rw));
            if (e.n_rw == 1) chk("regwrite_cycle", 32'(m_rw_cyc), 32'(e.done_cyc - 1));
          end
          m_req = 0; m_stall = 0; m_rw = 0; m_rw_cyc = -1;
        end
      end
    end
  end

  // Issues one instruction in the current cycle and returns #1 after the
  // edge that follows the expected done cycle (the next accept slot).
  task automatic run_op(input vec_t v);
    exp_t x;
    int   c0;
    c0 = cyc;
    x.done_cyc = c0 + v.lat; x.n_req = v.n_req; x.n_stall = v.lat - 1;
    x.n_rw = v.n_rw; x.ill = v.ill; x.tmo = v.tmo; x.mis = v.mis;
    x.we = v.we; x.imm = v.imm; x.aborted = 1'b0; x.addr = v.addr;
    q.push_back(x);
    instr_valid = 1'b1;
    Instr       = v.ins;
    alu_result  = v.addr;
    mem_ready   = v.noise;
    @(posedge clk); #1;
    instr_valid = v.noise;
    Instr       = v.noise ? I_ADD : v.ins;
    mem_ready   = v.noise;
    while (cyc < c0 + v.lat + 1) begin
      @(posedge clk); #1;
      instr_valid = v.noise && (cyc < c0 + v.lat);
      mem_ready   = (v.wait_n >= 0) && (cyc == c0 + 2 + v.wait_n);
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
  endtask

  initial begin
    exp_t ab;
    int   c0;
    rst = 1'b1; instr_valid = 1'b0; Instr = '0; alu_result = '0; mem_ready = 1'b0;

    //             instr  addr          wait nz lat req rw ill tmo mis we imm
    vecs[0] = mk(I_LW,  32'h0000_0108,  0, 0,  4,  1, 1, 0, 0, 0, 0, 0);
    vecs[1] = mk(I_SW,  32'h0000_010C,  3, 0,  6,  4, 0, 0, 0, 0, 1, 1);
    vecs[2] = mk(I_LW,  32'h0000_0200, -1, 0, 18, 16, 0, 0, 1, 0, 0, 0);
    vecs[3] = mk(I_LW,  32'h0000_0204, 15, 0, 19, 16, 1, 0, 0, 0, 0, 0);
    vecs[4] = mk(I_ADD, 32'h0000_0000,  0, 0,  1,  0, 0, 1, 0, 0, 0, 0);
    vecs[5] = mk(I_SW,  32'h0000_0FF0,  0, 0,  3,  1, 0, 0, 0, 0, 1, 1);
    vecs[6] = mk(I_LW,  32'h0000_03FC,  2, 1,  6,  3, 1, 0, 0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    vecs[7] = mk(I_LW,  32'h0000_0102,  0, 0,  2,  0, 0, 0, 0, 1, 0, 0);
`else
    vecs[7] = mk(I_LW,  32'h0000_0102,  0, 0,  4,  1, 1, 0, 0, 0, 0, 0);
`endif
    vecs[8] = mk(I_LB,  32'h0000_0100,  0, 0,  1,  0, 0, 1, 0, 0, 0, 0);
    vecs[9] = mk(I_SH,  32'h0000_0100,  0, 0,  1,  0, 0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Reset during MEM of a store: no done, outputs cleared next cycle.
    ab.done_cyc = -1; ab.n_req = 0; ab.n_stall = 0; ab.n_rw = 0;
    ab.ill = 0; ab.tmo = 0; ab.mis = 0; ab.we = 1; ab.imm = 1;
    ab.aborted = 1; ab.addr = 32'h0000_0110;
    q.push_back(ab);
    c0 = cyc;
    instr_valid = 1'b1; Instr = I_SW; alu_result = 32'h0000_0110;
    @(posedge clk); #1 instr_valid = 1'b0;
    while (cyc < c0 + 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[0]);

    repeat (4) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
